// File: rtl/writeback_stage_if.sv
// Handshake and register-file write bus of the writeback stage.
// The master side offers ALU/MEM results; the slave side is the writeback stage itself.
interface writeback_stage_if #(
    parameter int unsigned registerSize  = 8,
    parameter int unsigned vectorSize    = 4,
    parameter int unsigned selectionBits = 2
);
    logic                                       alu_valid;
    logic                                       alu_ready;
    logic [selectionBits:0]                     alu_dest;
    logic [vectorSize-1:0][registerSize-1:0]    alu_data;

    logic                                       mem_valid;
    logic                                       mem_ready;
    logic [selectionBits:0]                     mem_dest;
    logic [vectorSize-1:0][registerSize-1:0]    mem_data;

    logic                                       regWrEnSc;
    logic                                       regWrEnVec;
    logic [selectionBits:0]                     regToWrite;
    logic [vectorSize-1:0][registerSize-1:0]    dataIn;
    logic [2**(selectionBits+1)-1:0]            pend_mask;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready,
        input  regWrEnSc, regWrEnVec, regToWrite, dataIn, pend_mask
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready,
        output regWrEnSc, regWrEnVec, regToWrite, dataIn, pend_mask
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: one-entry ALU and MEM slots, oldest-first arbitration onto the
// single register-file write port, plus a pending-destination mask for hazard stalls.
module writeback_stage #(
    parameter int unsigned registerSize  = 8,
    parameter int unsigned vectorSize    = 4,
    parameter int unsigned selectionBits = 2
) (
    input logic               clk,
    input logic               reset,
    writeback_stage_if.slave  bus
);
    localparam int unsigned DestW   = selectionBits + 1;
    localparam int unsigned NumRegs = 2 ** DestW;

    typedef logic [DestW-1:0]                         dest_t;
    typedef logic [vectorSize-1:0][registerSize-1:0]  data_t;

    logic  alu_v_q, alu_v_d;
    dest_t alu_dest_q, alu_dest_d;
    data_t alu_data_q, alu_data_d;

    logic  mem_v_q, mem_v_d;
    dest_t mem_dest_q, mem_dest_d;
    data_t mem_data_q, mem_data_d;

    logic  mem_older_q, mem_older_d;

    logic  wr_valid_q, wr_valid_d;
    dest_t wr_dest_q, wr_dest_d;
    data_t wr_data_q, wr_data_d;

    logic  alu_grant, mem_grant;
    logic  alu_rdy, mem_rdy;
    logic  alu_acc, mem_acc;
    logic [NumRegs-1:0] pend;

    always_comb begin
        alu_grant = alu_v_q && (!mem_v_q || !mem_older_q);
        mem_grant = mem_v_q && (!alu_v_q || mem_older_q);
        // Ready looks only at slot state, never at the incoming valids.
        alu_rdy   = !reset && (!alu_v_q || alu_grant);
        mem_rdy   = !reset && (!mem_v_q || mem_grant);
        alu_acc   = bus.alu_valid && alu_rdy;
        mem_acc   = bus.mem_valid && mem_rdy;
    end

    always_comb begin
        alu_v_d    = alu_v_q;
        alu_dest_d = alu_dest_q;
        alu_data_d = alu_data_q;
        if (alu_grant) begin
            alu_v_d = 1'b0;
        end
        if (alu_acc) begin
            alu_v_d    = 1'b1;
            alu_dest_d = bus.alu_dest;
            alu_data_d = bus.alu_data;
        end

        mem_v_d    = mem_v_q;
        mem_dest_d = mem_dest_q;
        mem_data_d = mem_data_q;
        if (mem_grant) begin
            mem_v_d = 1'b0;
        end
        if (mem_acc) begin
            mem_v_d    = 1'b1;
            mem_dest_d = bus.mem_dest;
            mem_data_d = bus.mem_data;
        end

        // A fresh ALU entry is younger than a MEM entry that stays put; a fresh MEM
        // entry (alone or tied with ALU) is never the older one.
        mem_older_d = mem_older_q;
        if (alu_acc && mem_acc) begin
            mem_older_d = 1'b0;
        end else if (alu_acc) begin
            mem_older_d = mem_v_q && !mem_grant;
        end else if (mem_acc) begin
            mem_older_d = 1'b0;
        end

        wr_valid_d = alu_grant || mem_grant;
        wr_dest_d  = wr_dest_q;
        wr_data_d  = wr_data_q;
        if (alu_grant) begin
            wr_dest_d = alu_dest_q;
            wr_data_d = alu_data_q;
        end else if (mem_grant) begin
            wr_dest_d = mem_dest_q;
            wr_data_d = mem_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_v_q     <= 1'b0;
            alu_dest_q  <= '0;
            alu_data_q  <= '0;
            mem_v_q     <= 1'b0;
            mem_dest_q  <= '0;
            mem_data_q  <= '0;
            mem_older_q <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_dest_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            alu_v_q     <= alu_v_d;
            alu_dest_q  <= alu_dest_d;
            alu_data_q  <= alu_data_d;
            mem_v_q     <= mem_v_d;
            mem_dest_q  <= mem_dest_d;
            mem_data_q  <= mem_data_d;
            mem_older_q <= mem_older_d;
            wr_valid_q  <= wr_valid_d;
            wr_dest_q   <= wr_dest_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        pend = '0;
        if (alu_v_q) begin
            pend[alu_dest_q] = 1'b1;
        end
        if (mem_v_q) begin
            pend[mem_dest_q] = 1'b1;
        end
        if (wr_valid_q) begin
            pend[wr_dest_q] = 1'b1;
        end
    end

    assign bus.alu_ready  = alu_rdy;
    assign bus.mem_ready  = mem_rdy;
    assign bus.regWrEnSc  = wr_valid_q && wr_dest_q[selectionBits];
    assign bus.regWrEnVec = wr_valid_q && !wr_dest_q[selectionBits];
    assign bus.regToWrite = wr_dest_q;
    assign bus.dataIn     = wr_data_q;
    assign bus.pend_mask  = pend;
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: results retire in global acceptance order
// (ALU before MEM on a tie), one per cycle, no earlier than the cycle after acceptance+1.
module tb_writeback_stage;
    localparam int unsigned RS = 8;
    localparam int unsigned VS = 4;
    localparam int unsigned SB = 2;

    typedef struct {
        logic [2:0]  dest;
        logic [31:0] data;
        int          n;   // accept edge
        int          w;   // cycle in which the write enable must be high
    } item_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    writeback_stage_if #(.registerSize(RS), .vectorSize(VS), .selectionBits(SB)) bus();

    writeback_stage #(.registerSize(RS), .vectorSize(VS), .selectionBits(SB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    bit    mon_on = 1'b0;
    bit    alu_took = 1'b0;
    bit    mem_took = 1'b0;
    int    last_w = 0;
    int    alu_last_w = 0;
    int    mem_last_w = 0;
    item_t exp_q[$];
    item_t it;
    logic [7:0]  pend_e;
    logic [2:0]  out_dest_m = '0;
    logic [31:0] out_data_m = '0;
    bit    we_exp;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            check("alu_ready", 64'(bus.alu_ready), 64'(!reset && (alu_last_w <= cyc + 1)));
            check("mem_ready", 64'(bus.mem_ready), 64'(!reset && (mem_last_w <= cyc + 1)));

            pend_e = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].n <= cyc) pend_e[exp_q[i].dest] = 1'b1;
            end
            check("pend_mask", 64'(bus.pend_mask), 64'(pend_e));

            we_exp = (exp_q.size() > 0) && (exp_q[0].w == cyc);
            if (we_exp) begin
                it = exp_q.pop_front();
                check("regWrEnSc", 64'(bus.regWrEnSc), 64'(it.dest[2]));
                check("regWrEnVec", 64'(bus.regWrEnVec), 64'(!it.dest[2]));
                out_dest_m = it.dest;
                out_data_m = it.data;
            end else begin
                check("regWrEnSc_idle", 64'(bus.regWrEnSc), 64'(0));
                check("regWrEnVec_idle", 64'(bus.regWrEnVec), 64'(0));
            end
            check("regToWrite", 64'(bus.regToWrite), 64'(out_dest_m));
            check("dataIn", 64'(bus.dataIn), 64'(out_data_m));

            alu_took = bus.alu_valid && bus.alu_ready;
            mem_took = bus.mem_valid && bus.mem_ready;
            if (alu_took) begin
                it.dest = bus.alu_dest;
                it.data = bus.alu_data;
                it.n    = cyc + 1;
                it.w    = max2(it.n + 1, last_w + 1);
                last_w  = it.w;
                alu_last_w = it.w;
                exp_q.push_back(it);
            end
            if (mem_took) begin
                it.dest = bus.mem_dest;
                it.data = bus.mem_data;
                it.n    = cyc + 1;
                it.w    = max2(it.n + 1, last_w + 1);
                last_w  = it.w;
                mem_last_w = it.w;
                exp_q.push_back(it);
            end

            if (reset) begin
                exp_q.delete();
                last_w     = 0;
                alu_last_w = 0;
                mem_last_w = 0;
                out_dest_m = '0;
                out_data_m = '0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (alu_took) bus.alu_valid = 1'b0;
        if (mem_took) bus.mem_valid = 1'b0;
    endtask

    task automatic offer_alu(input logic [2:0] d, input logic [31:0] x);
        bus.alu_valid = 1'b1;
        bus.alu_dest  = d;
        bus.alu_data  = x;
    endtask

    task automatic offer_mem(input logic [2:0] d, input logic [31:0] x);
        bus.mem_valid = 1'b1;
        bus.mem_dest  = d;
        bus.mem_data  = x;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((bus.alu_valid || bus.mem_valid || exp_q.size() != 0) && k < budget) begin
            step();
            k++;
        end
        total++;
        if (bus.alu_valid || bus.mem_valid || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain cycle=%0d actual=%0d_pending required=0_pending", cyc,
                     exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.alu_valid = 1'b0;
        bus.alu_dest  = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_dest  = '0;
        bus.mem_data  = '0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        mon_on = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();

        // Single ALU vector write
        offer_alu(3'b001, 32'h44332211);
        drain(20);

        // Scalar write from memory
        offer_mem(3'b110, {24'h5a3c7e, 8'hA5});
        drain(20);

        // Simultaneous accept, same destination
        offer_alu(3'b010, 32'h00000001);
        offer_mem(3'b010, 32'h00000002);
        drain(20);

        // Age order: MEM accepted one cycle before the newer ALU entry
        offer_alu(3'b011, 32'hdeadbeef);
        step();
        offer_mem(3'b100, 32'hcafef00d);
        step();
        offer_alu(3'b101, 32'h12345678);
        drain(20);

        // ALU streaming back-to-back
        for (int i = 0; i < 8; i++) begin
            offer_alu(3'(i), 32'h10203040 + 32'(i));
            step();
        end
        drain(20);

        // Reset with both slots and the output register occupied
        offer_alu(3'b000, 32'h0badf00d);
        offer_mem(3'b111, 32'h00c0ffee);
        step();
        offer_alu(3'b001, 32'h11111111);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        step();
        drain(20);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if (!bus.alu_valid && $urandom_range(0, 2) != 0)
                offer_alu(3'($urandom_range(0, 7)), $urandom());
            if (!bus.mem_valid && $urandom_range(0, 3) != 0)
                offer_mem(3'($urandom_range(0, 7)), $urandom());
            reset = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0;
        drain(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
